serial_adder_unit: RTL and testbench
====================================

// Module: serial_adder_unit
// PURPOSE
//  Parametrised successor to the single-bit combinational full adder. Adds or subtracts two
//  WIDTH-bit operands digit-serially, BPC bits per clock, through a chain of 1-bit full-adder cells.
//  A registered carry links successive digits. Valid/ready handshakes on input and output.
//  Sits behind the TinyTapeout top-level pin mux as a small arithmetic engine.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; WIDTH >= 2
//  BPC    1  bits processed per cycle (cells in chain); WIDTH % BPC == 0 (elaboration error otherwise)
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst_n      in   1      reset, synchronous, active-low
//  ena        in   1      clock enable; 0 freezes all state, outputs hold
//  in_valid   in   1      operand pair offered
//  in_ready   out  1      unit idle, can accept operands
//  op_a       in   WIDTH  operand A (unsigned or two's complement)
//  op_b       in   WIDTH  operand B
//  sub        in   1      0: A+B+cin; 1: A-B-cin (computed as A + ~B + ~cin)
//  cin        in   1      carry-in (add) / borrow-in (sub)
//  out_valid  out  1      result available
//  out_ready  in   1      consumer takes result
//  sum        out  WIDTH  result
//  cout       out  1      carry out of MSB (for sub: 1 = no borrow)
//  ovf        out  1      signed overflow = carry into MSB XOR carry out of MSB
//  busy       out  1      high in RUN state
// BEHAVIOUR
//  Reset (rst_n=0 on an edge): state=IDLE, sum=0, cout=0, ovf=0, out_valid=0, busy=0, in_ready=1 after
//   that edge. Reset mid-RUN or mid-DONE aborts: partial result discarded, no out_valid.
//  FSM: IDLE -> RUN on in_valid&&in_ready&&ena; RUN -> DONE after NDIG=WIDTH/BPC digit cycles;
//   DONE -> IDLE on out_ready&&ena. in_ready=(state==IDLE); out_valid=(state==DONE); busy=(state==RUN).
//  Accept edge: latch A; B^{WIDTH{sub}}; carry register=cin^sub; digit counter=0; shift-out cleared.
//  RUN, each enabled edge: BPC cells add the low BPC bits of A, B' and carry; BPC sum bits shift into
//   result MSB end; A and B' shift right by BPC; carry register takes chain carry-out; counter++.
//   On the last digit, record carry into MSB for ovf.
//  Latency: out_valid rises exactly NDIG enabled cycles after the accept edge (WIDTH=8, BPC=1: 8).
//  sum/cout/ovf registered; valid in DONE; hold through IDLE until next DONE overwrites.
//  Width rule: sum = (A op B op cin) mod 2^WIDTH; cout = bit WIDTH of unsigned A+B'+carry_in.
//  in_valid while not IDLE: ignored, not queued. Operand changes after acceptance: no effect.
//  out_ready while not DONE: ignored. No back-to-back overlap: min 1 IDLE cycle between jobs.
//  ena=0 in any state: nothing advances, including handshakes; counter and carry held.
//  Counter width clog2(NDIG+1); terminal count is NDIG-1 at the last RUN edge.
// STRUCTURE
//  Package serial_adder_pkg: state enum {S_IDLE, S_RUN, S_DONE} (2 bits), localparam function for
//   NDIG and counter width.
//  Sub-module full_adder_cell (a, b, ci -> s, co; s=a^b^ci, co=maj(a,b,ci)), instantiated BPC times
//   in a generate-for carry chain. Everything else (FSM, shift registers, counter, output regs) in top.
// TESTING (WIDTH=8, BPC=1 unless noted)
//  1 add: A=0x3C, B=0x05, sub=0, cin=1 -> after 8 cycles sum=0x42, cout=0, ovf=0, out_valid=1
//  2 sub/overflow: A=0x7F, B=0xFF, sub=1, cin=0 -> sum=0x80, cout=0, ovf=1; A=0x10, B=0x01 -> sum=0x0F, cout=1
//  3 wrap: A=0xFF, B=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; BPC=4 and BPC=8 -> same, latency 2 / 1
//  4 backpressure: out_ready=0 for 5 cycles -> out_valid, sum held stable; in_valid ignored (in_ready=0)
//  5 ena stall: ena=0 for 3 cycles mid-RUN -> out_valid at 8+3 cycles after accept, result unchanged
//  6 reset mid-RUN at digit 4 -> next edge: IDLE, in_ready=1, sum=0, no out_valid; next job correct

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
// Digit count and counter width are derived from WIDTH and BPC.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int ndig(input int width, input int bpc);
    return width / bpc;
  endfunction

  function automatic int cnt_width(input int width, input int bpc);
    return $clog2(width / bpc + 1);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder; one link of the per-digit carry chain.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder_unit.sv
// Digit-serial add/subtract engine: BPC bits per cycle through a full-adder chain,
// with a registered carry between digits and valid/ready handshakes on both sides.
module serial_adder_unit
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NDIG = ndig(WIDTH, BPC);
  localparam int CW   = cnt_width(WIDTH, BPC);

  if (WIDTH < 2 || (WIDTH % BPC) != 0) begin : g_bad_params
    $error("serial_adder_unit: WIDTH must be >= 2 and a multiple of BPC");
  end

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_next;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic [BPC:0]     w_c;
  logic [BPC-1:0]   w_s;

  // Carry chain: cell gi handles bit gi of the current digit.
  assign w_c[0] = r_carry;
  for (genvar gi = 0; gi < BPC; gi++) begin : g_chain
    full_adder_cell u_cell (
      .a  (r_a[gi]),
      .b  (r_b[gi]),
      .ci (w_c[gi]),
      .s  (w_s[gi]),
      .co (w_c[gi+1])
    );
  end

  // New digit enters at the MSB end so the result lands LSB-aligned after NDIG digits.
  if (BPC == WIDTH) begin : g_shift_full
    assign w_shift_next = w_s;
  end else begin : g_shift_part
    assign w_shift_next = {w_s, r_shift[WIDTH-1:BPC]};
  end

  assign w_last = (r_cnt == CW'(NDIG - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (ena) begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && ena) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (ena) begin
      if (w_accept) begin
        r_a     <= op_a;
        r_b     <= op_b ^ {WIDTH{sub}};
        r_carry <= cin ^ sub;
        r_cnt   <= '0;
        r_shift <= '0;
      end else if (r_state == S_RUN) begin
        r_a     <= r_a >> BPC;
        r_b     <= r_b >> BPC;
        r_carry <= w_c[BPC];
        r_shift <= w_shift_next;
        r_cnt   <= r_cnt + 1'b1;
        if (w_last) begin
          // On the last digit the top cell sits on the MSB, so its carry-in is the carry into the MSB.
          r_sum  <= w_shift_next;
          r_cout <= w_c[BPC];
          r_ovf  <= w_c[BPC] ^ w_c[BPC-1];
        end
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder_unit.sv
// Directed bench: three instances (BPC=1,4,8) share stimulus; table rows plus
// hand-written sequences for backpressure, clock-enable stall and mid-run reset.
module tb_serial_adder_unit;

  logic       clk = 1'b0;
  logic       rst_n, ena, in_valid, out_ready, sub, cin;
  logic [7:0] op_a, op_b;

  logic       in_ready_o [3];
  logic       out_valid_o[3];
  logic [7:0] sum_o      [3];
  logic       cout_o     [3];
  logic       ovf_o      [3];
  logic       busy_o     [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder_unit #(.WIDTH(8), .BPC(1)) u_bpc1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready_o[0]),
    .op_a(op_a), .op_b(op_b), .sub(sub), .cin(cin), .out_valid(out_valid_o[0]),
    .out_ready(out_ready), .sum(sum_o[0]), .cout(cout_o[0]), .ovf(ovf_o[0]), .busy(busy_o[0]));

  serial_adder_unit #(.WIDTH(8), .BPC(4)) u_bpc4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready_o[1]),
    .op_a(op_a), .op_b(op_b), .sub(sub), .cin(cin), .out_valid(out_valid_o[1]),
    .out_ready(out_ready), .sum(sum_o[1]), .cout(cout_o[1]), .ovf(ovf_o[1]), .busy(busy_o[1]));

  serial_adder_unit #(.WIDTH(8), .BPC(8)) u_bpc8 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready_o[2]),
    .op_a(op_a), .op_b(op_b), .sub(sub), .cin(cin), .out_valid(out_valid_o[2]),
    .out_ready(out_ready), .sum(sum_o[2]), .cout(cout_o[2]), .ovf(ovf_o[2]), .busy(busy_o[2]));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[7];
  int   exp_lat[3] = '{8, 2, 1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Offers one operand pair; returns after the accept edge with in_valid dropped.
  task automatic start_job(input logic [7:0] a, input logic [7:0] b,
                           input logic s, input logic c);
    op_a = a; op_b = b; sub = s; cin = c; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op_a = 8'hA5; op_b = 8'h5A;
  endtask

  initial begin
    int lat[3];
    int seen;

    vecs[0] = '{8'h3C, 8'h05, 1'b0, 1'b1, 8'h42, 1'b0, 1'b0};
    vecs[1] = '{8'h7F, 8'hFF, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{8'h10, 8'h01, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[6] = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};

    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op_a = '0; op_b = '0; sub = 1'b0; cin = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_in_ready[%0d]", d),  in_ready_o[d],  1);
      chk($sformatf("reset_out_valid[%0d]", d), out_valid_o[d], 0);
      chk($sformatf("reset_busy[%0d]", d),      busy_o[d],      0);
      chk($sformatf("reset_sum[%0d]", d),       sum_o[d],       0);
    end

    // Table-driven jobs, all three digit widths in parallel
    foreach (vecs[i]) begin
      lat = '{0, 0, 0};
      start_job(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
      chk($sformatf("v%0d_busy_bpc1", i), busy_o[0], 1);
      for (int k = 1; k <= 12; k++) begin
        tick();
        for (int d = 0; d < 3; d++)
          if (out_valid_o[d] && lat[d] == 0) lat[d] = k;
      end
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("v%0d_lat[%0d]", i, d),  lat[d],    exp_lat[d]);
        chk($sformatf("v%0d_sum[%0d]", i, d),  sum_o[d],  vecs[i].exp_sum);
        chk($sformatf("v%0d_cout[%0d]", i, d), cout_o[d], vecs[i].exp_cout);
        chk($sformatf("v%0d_ovf[%0d]", i, d),  ovf_o[d],  vecs[i].exp_ovf);
        chk($sformatf("v%0d_idle[%0d]", i, d), in_ready_o[d], 1);
      end
    end

    // Backpressure: result held, new offers ignored
    out_ready = 1'b0;
    start_job(8'h3C, 8'h05, 1'b0, 1'b1);
    seen = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      tick();
      if (out_valid_o[0]) seen = k;
    end
    chk("bp_latency", seen, 8);
    op_a = 8'h11; op_b = 8'h22; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("bp_valid_%0d", k), out_valid_o[0], 1);
      chk($sformatf("bp_sum_%0d", k),   sum_o[0],       8'h42);
      chk($sformatf("bp_ready_%0d", k), in_ready_o[0],  0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", out_valid_o[0], 0);
    chk("bp_release_ready", in_ready_o[0],  1);
    chk("bp_release_sum",   sum_o[0],       8'h42);

    // Clock-enable stall for 3 cycles mid-run
    start_job(8'h10, 8'h01, 1'b1, 1'b0);
    seen = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      ena = !(k >= 5 && k <= 7);
      tick();
      if (k == 6) chk("stall_busy", busy_o[0], 1);
      if (out_valid_o[0]) seen = k;
    end
    ena = 1'b1;
    chk("stall_latency", seen, 11);
    chk("stall_sum",  sum_o[0],  8'h0F);
    chk("stall_cout", cout_o[0], 1);
    tick();

    // Reset at digit 4 aborts the job
    start_job(8'hFF, 8'h01, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_in_ready",  in_ready_o[0],  1);
    chk("rst_out_valid", out_valid_o[0], 0);
    chk("rst_busy",      busy_o[0],      0);
    chk("rst_sum",       sum_o[0],       0);
    chk("rst_cout",      cout_o[0],      0);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (out_valid_o[0]) seen = 1;
    end
    chk("rst_no_valid", seen, 0);

    start_job(8'h3C, 8'h05, 1'b0, 1'b1);
    seen = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      tick();
      if (out_valid_o[0]) seen = k;
    end
    chk("post_rst_latency", seen, 8);
    chk("post_rst_sum",     sum_o[0], 8'h42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
